key_event_queue: RTL and testbench

//  Sits directly downstream of the keyboard scanner. Consumes its four 8-bit physical key rows
//  (32 keys), debounces them by periodic sampling, and detects press edges. Queues the press

---
 rtl/key_pkg.sv | 28 ++
 rtl/key_fifo.sv | 63 ++++++
 rtl/key_event_queue.sv | 142 ++++++++++++++
 tb/tb_key_event_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: constants, types and helpers shared by the key event queue.
//   KEY_COUNT    number of physical keys (4 rows x 8)
//   KEY_IDX_W    width of a key index
//   KEY_CODE_W   width of a queued event code {release, index}
//   KEY_REL_BIT  position of the release flag in an event code
package key_pkg;

  localparam int KEY_COUNT   = 32;
  localparam int KEY_IDX_W   = 5;
  localparam int KEY_CODE_W  = 6;
  localparam int KEY_REL_BIT = 5;

  // Bit i of a key_vec_t is key index i (not the raw scanner bit position).
  typedef logic [KEY_COUNT-1:0]  key_vec_t;
  typedef logic [KEY_IDX_W-1:0]  key_idx_t;
  typedef logic [KEY_CODE_W-1:0] key_code_t;

  // Lowest set index of v. Scans downward so the last hit is the lowest; 0 when v is empty.
  function automatic key_idx_t lowest_idx(input key_vec_t v);
    key_idx_t idx;
    idx = '0;
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous FIFO for key event codes.
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request / data (ignored while full, even if a pop happens too)
//   pop, dout     read request / head entry (pop ignored while empty, dout = 0 when empty)
//   full, empty   occupancy flags
//   count         entries held, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module key_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push & ~do_pop) count_d = count_q + 1'b1;
    if (do_pop & ~do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through dout, which is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: debounces the 32 scanner keys by periodic sampling, turns confirmed
// press edges into 6-bit event codes and queues them for a valid/ack consumer.
//   clk, rst            clock, synchronous active-high reset
//   key_row1..key_row4  raw key state, 1 = pressed; key_row1[7] is key 0, key_row4[0] is key 31
//   key_valid/key_code  head of the event queue, code = {release flag, key index}
//   key_ack             pops the head when key_valid is high
//   key_down            some debounced key is held
//   key_overflow        sticky: a new edge merged into an event that was still pending
// Optional feature: define KEY_RELEASE_EVENTS_EN to also queue release events
// ({1'b1, index}), which always go after any pending presses.
module key_event_queue
  import key_pkg::*;
#(
  parameter logic [15:0] SAMPLE_DIV = 16'd50000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            key_row1,
  input  logic [7:0]            key_row2,
  input  logic [7:0]            key_row3,
  input  logic [7:0]            key_row4,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  input  logic                  key_ack,
  output logic                  key_down,
  output logic                  key_overflow
);

  logic [31:0] raw;
  key_vec_t    keys;

  logic [15:0] cnt_q, cnt_d;
  logic        tick;
  key_vec_t    samp_q, samp_d;
  key_vec_t    stab_q, stab_d;
  key_vec_t    press_q, press_d;
  key_vec_t    pend_p_q, pend_p_d;
  logic        overflow_q, overflow_d;

  key_vec_t    sel_vec, clr;
  key_idx_t    push_idx;
  key_code_t   push_code;
  logic        any_p, push;

  logic        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt_unused;

`ifdef KEY_RELEASE_EVENTS_EN
  key_vec_t    rel_q, rel_d;
  key_vec_t    pend_r_q, pend_r_d;
`endif

  assign raw = {key_row1, key_row2, key_row3, key_row4};

  // Reorder so that bit i of keys is key index i (raw bit 31 is key 0).
  always_comb begin
    keys = '0;
    for (int i = 0; i < KEY_COUNT; i++) keys[i] = raw[KEY_COUNT-1-i];
  end

  always_comb begin
    tick  = (cnt_q == SAMPLE_DIV - 16'd1);
    cnt_d = tick ? '0 : cnt_q + 16'd1;

    // A key changes debounced state only after two equal consecutive samples.
    samp_d  = tick ? keys : samp_q;
    stab_d  = tick ? ((keys & ~(keys ^ samp_q)) | (stab_q & (keys ^ samp_q))) : stab_q;
    // Edges are registered before entering the pending masks, which puts key_valid
    // two edges after the confirming tick.
    press_d = tick ? (keys & samp_q & ~stab_q) : '0;

    // Presses drain first; releases only once no press is pending.
    any_p     = |pend_p_q;
`ifdef KEY_RELEASE_EVENTS_EN
    rel_d     = tick ? (~keys & ~samp_q & stab_q) : '0;
    sel_vec   = any_p ? pend_p_q : pend_r_q;
    push_idx  = lowest_idx(sel_vec);
    push_code = {~any_p, push_idx};
`else
    sel_vec   = pend_p_q;
    push_idx  = lowest_idx(sel_vec);
    push_code = {1'b0, push_idx};
`endif
    // A full FIFO refuses the push regardless of a same-cycle pop; the bit stays pending.
    push = ~fifo_full & (|sel_vec);
    clr  = push ? (key_vec_t'(1) << push_idx) : '0;

    pend_p_d   = (pend_p_q & ~(any_p ? clr : '0)) | press_q;
    overflow_d = overflow_q | (|(press_q & pend_p_q & ~(any_p ? clr : '0)));
`ifdef KEY_RELEASE_EVENTS_EN
    pend_r_d   = (pend_r_q & ~(any_p ? '0 : clr)) | rel_q;
    overflow_d = overflow_d | (|(rel_q & pend_r_q & ~(any_p ? '0 : clr)));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      samp_q     <= '0;
      stab_q     <= '0;
      press_q    <= '0;
      pend_p_q   <= '0;
      overflow_q <= 1'b0;
`ifdef KEY_RELEASE_EVENTS_EN
      rel_q      <= '0;
      pend_r_q   <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      stab_q     <= stab_d;
      press_q    <= press_d;
      pend_p_q   <= pend_p_d;
      overflow_q <= overflow_d;
`ifdef KEY_RELEASE_EVENTS_EN
      rel_q      <= rel_d;
      pend_r_q   <= pend_r_d;
`endif
    end
  end

  key_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_code),
    .pop   (key_ack),
    .dout  (key_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt_unused)
  );

  assign key_valid    = ~fifo_empty;
  assign key_down     = |stab_q;
  assign key_overflow = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with SAMPLE_DIV=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raw;
  logic        key_ack;
  logic        key_valid, key_down, key_overflow;
  logic [5:0]  key_code;
  int          cyc;
  int          n_vec = 0;
  int          n_err = 0;
  logic        saw;

  always #5 clk = ~clk;

  key_event_queue #(
    .SAMPLE_DIV (16'd4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_row1     (raw[31:24]),
    .key_row2     (raw[23:16]),
    .key_row3     (raw[15:8]),
    .key_row4     (raw[7:0]),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ack      (key_ack),
    .key_down     (key_down),
    .key_overflow (key_overflow)
  );

  // Mirrors the sample divider phase: edges with cyc % 4 == 0 (cyc > 0) are tick edges.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the next tick edge.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (((cyc % 4) != 0 || cyc == 0) && n < 8);
    if (n >= 8) chk("tick_timeout", 32'(n), 32'd0);
  endtask

  task automatic set_key(input int idx, input logic v);
    raw[31-idx] = v;
  endtask

  task automatic pop();
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
  endtask

  // Release everything and throw away whatever gets queued, without checking.
  task automatic drain();
    wait_tick();
    raw = '0;
    wait_tick();
    wait_tick();
    repeat (3) step();
    for (int k = 0; k < 16; k++) if (key_valid) pop();
  endtask

  initial begin
    rst = 1'b1; raw = '0; key_ack = 1'b0;
    step(); step();
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_down", key_down, 0);
    chk("rst_ovf", key_overflow, 0);
    rst = 1'b0;

    // 1: single key 0 held over two ticks, then released
    wait_tick(); set_key(0, 1);
    wait_tick(); wait_tick();
    chk("t1_down", key_down, 1);
    chk("t1_valid_tick", key_valid, 0);
    step();
    chk("t1_valid_1edge", key_valid, 0);
    step();
    chk("t1_valid_2edge", key_valid, 1);
    chk("t1_code", key_code, 6'h00);
    pop();
    chk("t1_popped", key_valid, 0);
    wait_tick(); set_key(0, 0);
    wait_tick(); wait_tick();
    chk("t1_up", key_down, 0);
    step(); step();
`ifdef KEY_RELEASE_EVENTS_EN
    chk("t1_rel_valid", key_valid, 1);
    chk("t1_rel_code", key_code, 6'h20);
    pop();
`else
    chk("t1_no_rel", key_valid, 0);
`endif

    // 2: key 31 toggling every cycle (always 0 at the tick samples), then held
    wait_tick();
    saw = 1'b0;
    for (int j = 0; j < 20; j++) begin
      set_key(31, (j % 2) == 0);
      step();
      if (key_valid || key_down) saw = 1'b1;
    end
    chk("t2_quiet", saw, 0);
    set_key(31, 1);
    wait_tick(); wait_tick(); step(); step();
    chk("t2_valid", key_valid, 1);
    chk("t2_code", key_code, 6'h1F);
    pop();
    chk("t2_single", key_valid, 0);
    drain();

    // 3: four keys confirmed on the same tick, drained in index order
    wait_tick();
    set_key(3, 1); set_key(9, 1); set_key(20, 1); set_key(31, 1);
    wait_tick(); wait_tick(); step(); step();
    chk("t3_first", key_code, 6'h03);
    repeat (3) step();
    chk("t3_head", key_code, 6'h03);
    pop(); chk("t3_pop1", key_code, 6'h09);
    pop(); chk("t3_pop2", key_code, 6'h14);
    pop(); chk("t3_pop3", key_code, 6'h1F);
    pop(); chk("t3_empty", key_valid, 0);
    drain();

    // 4: five keys on successive ticks into a 4-deep queue, then overflow merge on key 7
    wait_tick(); set_key(1, 1);
    wait_tick(); set_key(2, 1);
    wait_tick(); set_key(4, 1);
    wait_tick(); set_key(6, 1);
    wait_tick(); set_key(7, 1);
    wait_tick(); wait_tick(); repeat (3) step();
    chk("t4_valid", key_valid, 1);
    chk("t4_head", key_code, 6'h01);
    chk("t4_no_ovf", key_overflow, 0);
    wait_tick(); set_key(7, 0);
    wait_tick(); wait_tick(); set_key(7, 1);
    wait_tick(); wait_tick(); step(); step();
    chk("t4_ovf", key_overflow, 1);
    chk("t4_head_held", key_code, 6'h01);
    pop(); chk("t4_pop1", key_code, 6'h02);
    pop(); chk("t4_pop2", key_code, 6'h04);
    pop(); chk("t4_pop3", key_code, 6'h06);
    pop(); chk("t4_pop4", key_code, 6'h07);
    drain();

    // 5: reset with three queued events, then held keys reappear as presses
    wait_tick();
    set_key(11, 1); set_key(12, 1); set_key(13, 1);
    wait_tick(); wait_tick(); repeat (4) step();
    chk("t5_pre_valid", key_valid, 1);
    rst = 1'b1;
    step();
    chk("t5_valid", key_valid, 0);
    chk("t5_code", key_code, 0);
    chk("t5_ovf", key_overflow, 0);
    chk("t5_down", key_down, 0);
    rst = 1'b0;
    wait_tick(); wait_tick(); step(); step();
    chk("t5_again_valid", key_valid, 1);
    chk("t5_again_code", key_code, 6'h0B);
    drain();

    // 6: press then release key 10
    wait_tick(); set_key(10, 1);
    wait_tick(); wait_tick(); step(); step();
    chk("t6_press", key_code, 6'h0A);
    pop();
    wait_tick(); set_key(10, 0);
    wait_tick(); wait_tick(); step(); step();
`ifdef KEY_RELEASE_EVENTS_EN
    chk("t6_rel_valid", key_valid, 1);
    chk("t6_rel_code", key_code, 6'h2A);
    pop();
`else
    chk("t6_no_rel", key_valid, 0);
`endif
    chk("t6_end_empty", key_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
